// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that time-shares one serial sequence detector among NUM_REQ requesters.
// Optional build macro SEQ_SCHED_ZCNT_EN adds the per-frame z-high cycle counter (result_zcnt).
module seq_detect_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 8,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(FRAME_W+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic                       det_w,
  output logic                       det_reset,
  input  logic                       det_z,
  output logic                       result_valid,
  output logic [IDX_W-1:0]           result_id,
  output logic                       result_hit,
  output logic [CNT_W-1:0]           result_zcnt
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_e;

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                    gnt_q, gnt_d;
  logic [FRAME_W-1:0]                  shreg_q, shreg_d;
  logic [CNT_W-1:0]                    s_q, s_d;
  logic                                hit_acc_q, hit_acc_d;
  logic [IDX_W-1:0]                    res_id_q, res_id_d;
  logic                                res_hit_q, res_hit_d;
  logic [NUM_REQ-1:0][FRAME_W-1:0]     data_arr;
  logic [IDX_W-1:0]                    pick, cand;
  logic                                pick_vld;

  assign data_arr = req_data;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      shreg_q   <= '0;
      s_q       <= '0;
      hit_acc_q <= 1'b0;
      res_id_q  <= '0;
      res_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      shreg_q   <= shreg_d;
      s_q       <= s_d;
      hit_acc_q <= hit_acc_d;
      res_id_q  <= res_id_d;
      res_hit_q <= res_hit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    shreg_d      = shreg_q;
    s_d          = s_q;
    hit_acc_d    = hit_acc_q;
    res_id_d     = res_id_q;
    res_hit_d    = res_hit_q;
    det_w        = 1'b0;
    result_valid = 1'b0;
    ack          = '0;
    unique case (state_q)
      IDLE: if (pick_vld) begin
        gnt_d     = pick;
        shreg_d   = data_arr[pick];
        hit_acc_d = 1'b0;
        state_d   = CLR;
      end
      CLR: begin
        s_d     = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // MSB leaves first; det_z lags one bit, so the s=0 sample is the cleared state.
        det_w   = shreg_q[FRAME_W-1];
        shreg_d = shreg_q << 1;
        if (s_q != '0) hit_acc_d = hit_acc_q | det_z;
        s_d = s_q + 1'b1;
        if (s_q == CNT_W'(FRAME_W-1)) state_d = DRAIN;
      end
      DRAIN: begin
        res_id_d  = gnt_q;
        res_hit_d = hit_acc_q | det_z;
        state_d   = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        ack[gnt_q]   = 1'b1;
        rr_ptr_d     = (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign det_reset  = reset | (state_q == CLR);
  assign result_id  = res_id_q;
  assign result_hit = res_hit_q;

`ifdef SEQ_SCHED_ZCNT_EN
  logic [CNT_W-1:0] zcnt_acc_q, res_zcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      zcnt_acc_q <= '0;
      res_zcnt_q <= '0;
    end else begin
      if (state_q == IDLE && pick_vld)
        zcnt_acc_q <= '0;
      else if (state_q == SHIFT && s_q != '0)
        zcnt_acc_q <= zcnt_acc_q + CNT_W'(det_z);
      if (state_q == DRAIN)
        res_zcnt_q <= zcnt_acc_q + CNT_W'(det_z);
    end
  end

  assign result_zcnt = res_zcnt_q;
`else
  assign result_zcnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: drives a "1x1" pattern detector model and checks results
// against frame-level hit counts; zcnt expectations follow SEQ_SCHED_ZCNT_EN.
module tb_seq_detect_scheduler;
  localparam int NR = 4;
  localparam int FW = 8;
  localparam int IW = 2;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*FW-1:0]  req_data = '0;
  logic [NR-1:0]     ack;
  logic              busy, det_w, det_reset, det_z, result_valid, result_hit;
  logic [IW-1:0]     result_id;
  logic [CW-1:0]     result_zcnt;

  int passed = 0;
  int total  = 0;
  int res_pulses = 0;

  seq_detect_scheduler #(.NUM_REQ(NR), .FRAME_W(FW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .busy(busy),
    .det_w(det_w), .det_reset(det_reset), .det_z(det_z), .result_valid(result_valid),
    .result_id(result_id), .result_hit(result_hit), .result_zcnt(result_zcnt)
  );

  always #5 clk = ~clk;

  // Shared detector: registered z flags a 1 two bits after a previous 1 (patterns 101 / 111).
  logic dz = 1'b0, dw1 = 1'b0, dw2 = 1'b0;
  always @(posedge clk) begin
    if (det_reset) begin
      dz <= 1'b0; dw1 <= 1'b0; dw2 <= 1'b0;
    end else begin
      dz  <= det_w & dw2;
      dw2 <= dw1;
      dw1 <= det_w;
    end
  end
  assign det_z = dz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Frame-level reference: count positions k (MSB-first) where bit k and bit k-2 are both 1.
  function automatic int ref_cnt(input logic [FW-1:0] d);
    int c = 0;
    for (int k = 2; k < FW; k++)
      if (d[FW-1-k] && d[FW-1-(k-2)]) c++;
    return c;
  endfunction

  function automatic int exp_z(input int c);
`ifdef SEQ_SCHED_ZCNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (result_valid) res_pulses++;
    if (!reset && !result_valid && ack !== '0) chk("stray_ack", 64'(ack), 64'd0);
  end

  task automatic wait_res(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (result_valid !== 1'b1 && n < 60);
    if (result_valid !== 1'b1) n = -1;
  endtask

  task automatic chk_result(input string tag, input int id, input logic [FW-1:0] d);
    chk($sformatf("%s_id", tag), 64'(result_id), 64'(id));
    chk($sformatf("%s_hit", tag), 64'(result_hit), 64'(ref_cnt(d) != 0));
    chk($sformatf("%s_zcnt", tag), 64'(result_zcnt), 64'(exp_z(ref_cnt(d))));
    chk($sformatf("%s_ack", tag), 64'(ack), 64'(1 << id));
  endtask

  typedef struct {int id; logic [FW-1:0] data; logic hit; int zcnt;} vec_t;
  vec_t tbl [6];
  logic [FW-1:0] dat [NR];

  initial begin
    int n, m, p, e, r, first, hold_id;
    logic [FW-1:0] orig;

    tbl[0] = '{0, 8'b11100000, 1'b1, 1};
    tbl[1] = '{2, 8'b10101010, 1'b1, 3};
    tbl[2] = '{2, 8'b10010000, 1'b0, 0};
    tbl[3] = '{1, 8'b11111111, 1'b1, 6};
    tbl[4] = '{3, 8'b00000101, 1'b1, 1};
    tbl[5] = '{1, 8'b01010101, 1'b1, 3};

    // Power-on reset
    @(negedge clk);
    chk("por_det_reset", 64'(det_reset), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("por_busy", 64'(busy), 64'd0);
    chk("por_outs", 64'({ack, result_valid, result_id, result_hit, result_zcnt, det_w}), 64'd0);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      req_data[tbl[i].id*FW +: FW] = tbl[i].data;
      req = NR'(1 << tbl[i].id);
      wait_res(n);
      chk($sformatf("tbl%0d_lat", i), 64'(n), 64'd11);
      if (n > 0) begin
        chk($sformatf("tbl%0d_id", i), 64'(result_id), 64'(tbl[i].id));
        chk($sformatf("tbl%0d_hit", i), 64'(result_hit), 64'(tbl[i].hit));
        chk($sformatf("tbl%0d_zcnt", i), 64'(result_zcnt), 64'(exp_z(tbl[i].zcnt)));
        chk($sformatf("tbl%0d_ack", i), 64'(ack), 64'(1 << tbl[i].id));
      end
      req = '0;
      hold_id = tbl[i].id;
      @(negedge clk);
      chk($sformatf("tbl%0d_hold", i), 64'({result_valid, result_id}), 64'(hold_id));
    end

    // Reset for 3 cycles in the middle of a frame: aborted, no result, rr_ptr back to 0
    req_data[3*FW +: FW] = 8'b11111111;
    req = 4'b1000;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    r = res_pulses;
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_det_reset%0d", i), 64'(det_reset), 64'd1);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_outs", 64'({ack, result_valid, result_id, result_hit, result_zcnt, det_w, det_reset}), 64'd0);
    repeat (14) @(negedge clk);
    #1;
    chk("abort_no_result", 64'(res_pulses), 64'(r));

    // All requesters held: grants rotate 0,1,2,3,0 at 12-cycle spacing
    @(negedge clk);
    for (int i = 0; i < NR; i++) dat[i] = FW'($urandom);
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_res(n);
      chk($sformatf("rr%0d_spacing", i), 64'(n), 64'(i == 0 ? 11 : 12));
      if (n > 0) chk_result($sformatf("rr%0d", i), i % NR, dat[i % NR]);
    end
    req = '0;
    @(negedge clk);

    // req0 dropped and data changed mid-SHIFT: latched frame still completes
    orig = 8'b10111001;
    req_data[0 +: FW] = orig;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    req = '0;
    req_data[0 +: FW] = ~orig;
    wait_res(n);
    chk("drop_lat", 64'(n), 64'd7);
    if (n > 0) chk_result("drop", 0, orig);
    @(negedge clk);

    // Random request masks against a pending-set round-robin model
    p = 1;
    for (int rnd = 0; rnd < 15; rnd++) begin
      m = $urandom_range(1, (1 << NR) - 1);
      for (int i = 0; i < NR; i++) dat[i] = FW'($urandom);
      req_data = {dat[3], dat[2], dat[1], dat[0]};
      req = NR'(m);
      first = 1;
      for (int it = 0; it < 20 && m != 0; it++) begin
        wait_res(n);
        chk($sformatf("rnd%0d_lat", rnd), 64'(n), 64'(first ? 11 : 12));
        first = 0;
        e = -1;
        for (int k = NR-1; k >= 0; k--)
          if (m[(p + k) % NR]) e = (p + k) % NR;
        if (n > 0 && e >= 0) chk_result($sformatf("rnd%0d", rnd), e, dat[e]);
        if (n < 0) break;
        m &= ~(1 << e);
        p = (e + 1) % NR;
        if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, NR-1);
          if (!m[r]) begin
            dat[r] = FW'($urandom);
            m |= (1 << r);
          end
        end
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        req = NR'(m);
      end
      req = '0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
